block_hits: RTL and testbench

Brick-state manager for the Arkanoid playfield. It owns the 16-bit destroyed-block mask that the board renderer consumes. Once per frame it samples the ball position and scans the 16 bricks sequentially, one per clock. It then marks hit bricks destroyed, pulses a bounce request to the ball-motion logic and keeps the score. It sits between ball control and `draw_board` and drives `blocks_in` of the renderer.

---
 rtl/block_hits_if.sv | 29 ++
 rtl/block_hits.sv | 188 ++++++++++++++++++
 tb/tb_block_hits.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_hits_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// block_hits_if : ball/board handshake bundle between ball control, block_hits
//                 and the board renderer.   Rev 1.0
// ----------------------------------------------------------------------------
interface block_hits_if;
   logic        frame_tick;
   logic        level_reset;
   logic [10:0] ball_x;
   logic [10:0] ball_y;
   logic [15:0] blocks_out;
   logic        hit;
   logic        bounce_x;
   logic        bounce_y;
   logic [7:0]  score;
   logic        all_cleared;
   logic        busy;

   modport master (
      output frame_tick, level_reset, ball_x, ball_y,
      input  blocks_out, hit, bounce_x, bounce_y, score, all_cleared, busy
   );

   modport slave (
      input  frame_tick, level_reset, ball_x, ball_y,
      output blocks_out, hit, bounce_x, bounce_y, score, all_cleared, busy
   );
endinterface
`default_nettype wire

// File: rtl/block_hits.sv
`default_nettype none
// ----------------------------------------------------------------------------
// block_hits : per-frame sequential brick scan, hit resolve, bounce and score.
//              Option macro: BLOCK_HITS_MULTI_HIT_EN.   Rev 1.0
// ----------------------------------------------------------------------------
module block_hits #(
   parameter int HOR1      = 112,
   parameter int HOR2      = 312,
   parameter int HOR3      = 512,
   parameter int HOR4      = 712,
   parameter int VER1      = 50,
   parameter int VER2      = 130,
   parameter int VER3      = 210,
   parameter int VER4      = 290,
   parameter int B_WIDTH   = 100,
   parameter int B_HEIGHT  = 50,
   parameter int BALL_SIZE = 8
) (
   input  wire logic   pclk,
   input  wire logic   reset,
   block_hits_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SCAN    = 2'd1,
      ST_RESOLVE = 2'd2
   } state_t;

   state_t      state_q,   state_d;
   logic [3:0]  idx_q,     idx_d;
   logic [10:0] bx_q,      bx_d;
   logic [10:0] by_q,      by_d;
   logic [15:0] acc_q,     acc_d;
   logic        sel_y_q,   sel_y_d;
   logic [15:0] blocks_q,  blocks_d;
   logic [7:0]  score_q,   score_d;
   logic        hit_q,     hit_d;
   logic        bnc_x_q,   bnc_x_d;
   logic        bnc_y_q,   bnc_y_d;
   logic        cleared_q, cleared_d;

   function automatic logic [11:0] f_hor(input logic [1:0] col);
      case (col)
         2'd0:    return 12'(HOR1);
         2'd1:    return 12'(HOR2);
         2'd2:    return 12'(HOR3);
         default: return 12'(HOR4);
      endcase
   endfunction

   function automatic logic [11:0] f_ver(input logic [1:0] row);
      case (row)
         2'd0:    return 12'(VER1);
         2'd1:    return 12'(VER2);
         2'd2:    return 12'(VER3);
         default: return 12'(VER4);
      endcase
   endfunction

   function automatic logic [4:0] f_popcount(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
      return n;
   endfunction

   // 12-bit arithmetic keeps bx+BALL_SIZE-1 and HOR+B_WIDTH from wrapping
   logic [11:0] w_hor, w_ver, w_bx, w_by, w_cx;
   logic        w_overlap, w_centre_in, w_live;
   logic [15:0] w_onehot;
   logic [8:0]  w_sum;

   assign w_hor       = f_hor(idx_q[1:0]);
   assign w_ver       = f_ver(idx_q[3:2]);
   assign w_bx        = {1'b0, bx_q};
   assign w_by        = {1'b0, by_q};
   assign w_cx        = w_bx + 12'(BALL_SIZE / 2);
   assign w_overlap   = (w_bx + 12'(BALL_SIZE - 1) >= w_hor) &&
                        (w_bx <= w_hor + 12'(B_WIDTH)) &&
                        (w_by + 12'(BALL_SIZE - 1) >= w_ver) &&
                        (w_by <= w_ver + 12'(B_HEIGHT));
   assign w_centre_in = (w_cx >= w_hor) && (w_cx <= w_hor + 12'(B_WIDTH));
   assign w_live      = ~blocks_q[idx_q];
   assign w_onehot    = 16'd1 << idx_q;
   assign w_sum       = {1'b0, score_q} + {4'd0, f_popcount(acc_q)};

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      bx_d      = bx_q;
      by_d      = by_q;
      acc_d     = acc_q;
      sel_y_d   = sel_y_q;
      blocks_d  = blocks_q;
      score_d   = score_q;
      hit_d     = 1'b0;
      bnc_x_d   = 1'b0;
      bnc_y_d   = 1'b0;
      cleared_d = (blocks_q == 16'hFFFF);

      if (bus.level_reset) begin
         state_d   = ST_IDLE;
         blocks_d  = '0;
         cleared_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.frame_tick) begin
                  bx_d    = bus.ball_x;
                  by_d    = bus.ball_y;
                  idx_d   = 4'd0;
                  acc_d   = '0;
                  sel_y_d = 1'b0;
                  state_d = ST_SCAN;
               end
            end
            ST_SCAN: begin
               // bounce direction is decided by the first (lowest-index) hit
               if (w_overlap && w_live) begin
`ifdef BLOCK_HITS_MULTI_HIT_EN
                  acc_d = acc_q | w_onehot;
                  if (acc_q == '0) sel_y_d = w_centre_in;
`else
                  if (acc_q == '0) begin
                     acc_d   = w_onehot;
                     sel_y_d = w_centre_in;
                  end
`endif
               end
               idx_d = idx_q + 4'd1;
               if (idx_q == 4'd15) state_d = ST_RESOLVE;
            end
            ST_RESOLVE: begin
               if (acc_q != '0) begin
                  blocks_d = blocks_q | acc_q;
                  score_d  = w_sum[8] ? 8'hFF : w_sum[7:0];
                  hit_d    = 1'b1;
                  bnc_y_d  = sel_y_q;
                  bnc_x_d  = ~sel_y_q;
               end
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         bx_q      <= '0;
         by_q      <= '0;
         acc_q     <= '0;
         sel_y_q   <= 1'b0;
         blocks_q  <= '0;
         score_q   <= '0;
         hit_q     <= 1'b0;
         bnc_x_q   <= 1'b0;
         bnc_y_q   <= 1'b0;
         cleared_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         bx_q      <= bx_d;
         by_q      <= by_d;
         acc_q     <= acc_d;
         sel_y_q   <= sel_y_d;
         blocks_q  <= blocks_d;
         score_q   <= score_d;
         hit_q     <= hit_d;
         bnc_x_q   <= bnc_x_d;
         bnc_y_q   <= bnc_y_d;
         cleared_q <= cleared_d;
      end
   end

   assign bus.blocks_out  = blocks_q;
   assign bus.score       = score_q;
   assign bus.hit         = hit_q;
   assign bus.bounce_x    = bnc_x_q;
   assign bus.bounce_y    = bnc_y_q;
   assign bus.all_cleared = cleared_q;
   assign bus.busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_block_hits.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_block_hits : randomized + directed bench for block_hits against a
//                 brick-geometry reference model.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_block_hits;

   localparam int HOR[4] = '{112, 312, 512, 712};
   localparam int VER[4] = '{50, 130, 210, 290};
`ifdef BLOCK_HITS_MULTI_HIT_EN
   localparam bit MULTI = 1'b1;
`else
   localparam bit MULTI = 1'b0;
`endif

   logic pclk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [15:0] m_blocks = '0;
   logic [7:0]  m_score  = '0;

   block_hits_if bus();
   block_hits_if bus40();

   block_hits #(.BALL_SIZE(8))  u_dut   (.pclk(pclk), .reset(reset), .bus(bus));
   block_hits #(.BALL_SIZE(40)) u_dut40 (.pclk(pclk), .reset(reset), .bus(bus40));

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Geometry reference: which live bricks a ball of side sz at (x,y) destroys
   function automatic void model_scan(input logic [15:0] mask, input int x, input int y,
                                      input int sz, output logic [15:0] newh, output bit sel_y);
      int  h, v;
      bit  ov;
      newh  = '0;
      sel_y = 1'b0;
      for (int i = 0; i < 16; i++) begin
         h  = HOR[i % 4];
         v  = VER[i / 4];
         ov = (x + sz - 1 >= h) && (x <= h + 100) && (y + sz - 1 >= v) && (y <= v + 50);
         if (ov && !mask[i]) begin
            if (newh == '0) sel_y = (x + sz / 2 >= h) && (x + sz / 2 <= h + 100);
            if (MULTI || newh == '0) newh[i] = 1'b1;
         end
      end
   endfunction

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic run_frame(input logic [10:0] x, input logic [10:0] y);
      logic [15:0] newh, exp_blk;
      bit          sel;
      int          s;
      model_scan(m_blocks, int'(x), int'(y), 8, newh, sel);
      exp_blk = m_blocks | newh;
      s = int'(m_score) + $countones(newh);
      if (s > 255) s = 255;
      bus.ball_x = x;
      bus.ball_y = y;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      for (int k = 1; k <= 17; k++) begin
         n_checks++;
         if (bus.busy !== 1'b1 || bus.hit !== 1'b0 || bus.blocks_out !== m_blocks) begin
            n_fail++;
            $display("FAIL scan_cycle%0d: busy=%b hit=%b blocks=%h, required busy=1 hit=0 blocks=%h",
                     k, bus.busy, bus.hit, bus.blocks_out, m_blocks);
         end
         step();
      end
      n_checks++;
      if (bus.blocks_out !== exp_blk || bus.score !== 8'(s) || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL resolve(%0d,%0d): blocks=%h score=%0d busy=%b, required %h %0d 0",
                  x, y, bus.blocks_out, bus.score, bus.busy, exp_blk, s);
      end
      n_checks++;
      if (bus.hit !== (newh != '0) || bus.bounce_y !== ((newh != '0) && sel) ||
          bus.bounce_x !== ((newh != '0) && !sel)) begin
         n_fail++;
         $display("FAIL pulses(%0d,%0d): hit=%b bx=%b by=%b, required hit=%b sel_y=%b",
                  x, y, bus.hit, bus.bounce_x, bus.bounce_y, (newh != '0), sel);
      end
      m_blocks = exp_blk;
      m_score  = 8'(s);
      step();
      n_checks++;
      if (bus.all_cleared !== (m_blocks == 16'hFFFF) || bus.hit !== 1'b0 ||
          bus.bounce_x !== 1'b0 || bus.bounce_y !== 1'b0) begin
         n_fail++;
         $display("FAIL post_resolve: all_cleared=%b hit=%b bx=%b by=%b, required all_cleared=%b pulses 0",
                  bus.all_cleared, bus.hit, bus.bounce_x, bus.bounce_y, (m_blocks == 16'hFFFF));
      end
   endtask

   task automatic pulse_level_reset();
      bus.level_reset = 1'b1;
      step();
      bus.level_reset = 1'b0;
      m_blocks = '0;
      n_checks++;
      if (bus.blocks_out !== 16'h0 || bus.all_cleared !== 1'b0 || bus.score !== m_score || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL level_reset: blocks=%h all_cleared=%b score=%0d busy=%b, required 0 0 %0d 0",
                  bus.blocks_out, bus.all_cleared, bus.score, bus.busy, m_score);
      end
   endtask

   task automatic clear_round();
      for (int i = 0; i < 16; i++) run_frame(11'(HOR[i % 4] + 40), 11'(VER[i / 4] + 20));
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.frame_tick = 0; bus.level_reset = 0; bus.ball_x = 0; bus.ball_y = 0;
      bus40.frame_tick = 0; bus40.level_reset = 0; bus40.ball_x = 0; bus40.ball_y = 0;
      step();
      step();
      n_checks++;
      if ({bus.blocks_out, bus.score, bus.hit, bus.bounce_x, bus.bounce_y, bus.all_cleared, bus.busy} !== 29'd0) begin
         n_fail++;
         $display("FAIL reset_state: blocks=%h score=%0d hit=%b bx=%b by=%b clr=%b busy=%b, required all 0",
                  bus.blocks_out, bus.score, bus.hit, bus.bounce_x, bus.bounce_y, bus.all_cleared, bus.busy);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_first_brick();
      run_frame(11'd150, 11'd60);
      n_checks++;
      if (bus.blocks_out !== 16'h0001 || bus.score !== 8'd1) begin
         n_fail++;
         $display("FAIL first_brick: blocks=%h score=%0d, required 0001 1", bus.blocks_out, bus.score);
      end
      run_frame(11'd150, 11'd60);
      n_checks++;
      if (bus.score !== 8'd1) begin
         n_fail++;
         $display("FAIL repeat_no_score: score=%0d, required 1", bus.score);
      end
   endtask

   task automatic test_bounce_x();
      run_frame(11'd210, 11'd140);
      n_checks++;
      if (bus.blocks_out[4] !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_x_brick: blocks=%h, required bit4 set", bus.blocks_out);
      end
   endtask

   task automatic test_large_ball();
      logic [15:0] exp_b;
      exp_b = MULTI ? 16'h0011 : 16'h0001;
      bus40.ball_x = 11'd150;
      bus40.ball_y = 11'd95;
      bus40.frame_tick = 1'b1;
      step();
      bus40.frame_tick = 1'b0;
      for (int k = 1; k < 18; k++) step();
      n_checks++;
      if (bus40.blocks_out !== exp_b || bus40.score !== 8'($countones(exp_b)) || bus40.hit !== 1'b1) begin
         n_fail++;
         $display("FAIL large_ball: blocks=%h score=%0d hit=%b, required %h %0d 1",
                  bus40.blocks_out, bus40.score, bus40.hit, exp_b, $countones(exp_b));
      end
      step();
   endtask

   task automatic test_midscan_reset();
      bus.ball_x = 11'd350; bus.ball_y = 11'd60;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      for (int k = 1; k < 8; k++) step();
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.blocks_out, bus.score, bus.hit, bus.bounce_x, bus.bounce_y, bus.all_cleared, bus.busy} !== 29'd0) begin
         n_fail++;
         $display("FAIL midscan_reset: blocks=%h score=%0d busy=%b, required all 0",
                  bus.blocks_out, bus.score, bus.busy);
      end
      step();
      reset = 1'b1;
      step();
      m_blocks = '0;
      m_score  = '0;
      run_frame(11'd350, 11'd60);
   endtask

   task automatic test_clear_all();
      clear_round();
      n_checks++;
      if (bus.all_cleared !== 1'b1 || bus.score !== 8'd16 || bus.blocks_out !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL clear_all: all_cleared=%b score=%0d blocks=%h, required 1 16 FFFF",
                  bus.all_cleared, bus.score, bus.blocks_out);
      end
      pulse_level_reset();
   endtask

   task automatic test_random();
      int b, x, y;
      for (int n = 0; n < 40; n++) begin
         b = int'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) begin
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(0, 767));
         end else begin
            x = HOR[b % 4] - 10 + int'($urandom_range(0, 120));
            y = VER[b / 4] - 10 + int'($urandom_range(0, 70));
         end
         run_frame(11'(x), 11'(y));
      end
      pulse_level_reset();
   endtask

   task automatic test_tick_ignored();
      bus.ball_x = 11'd0; bus.ball_y = 11'd0;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         bus.frame_tick = (k == 5);
         n_checks++;
         if (bus.busy !== (k <= 17)) begin
            n_fail++;
            $display("FAIL tick_ignored_c%0d: busy=%b, required %b", k, bus.busy, (k <= 17));
         end
         step();
      end
      bus.frame_tick = 1'b0;
   endtask

   task automatic test_lr_abort();
      bus.ball_x = 11'd150; bus.ball_y = 11'd60;
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      for (int k = 1; k < 10; k++) step();
      bus.level_reset = 1'b1;
      step();
      bus.level_reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         n_checks++;
         if (bus.busy !== 1'b0 || bus.hit !== 1'b0 || bus.blocks_out !== 16'h0) begin
            n_fail++;
            $display("FAIL lr_abort_c%0d: busy=%b hit=%b blocks=%h, required 0 0 0000",
                     k, bus.busy, bus.hit, bus.blocks_out);
         end
         step();
      end
      bus.frame_tick = 1'b1;
      bus.level_reset = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      bus.level_reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lr_with_tick_c%0d: busy=%b, required 0", k, bus.busy);
         end
         step();
      end
   endtask

   task automatic test_saturate();
      while (m_score < 8'd255) begin
         clear_round();
         pulse_level_reset();
      end
      clear_round();
      n_checks++;
      if (bus.score !== 8'd255) begin
         n_fail++;
         $display("FAIL score_saturate: score=%0d, required 255", bus.score);
      end
   endtask

   initial begin
      test_reset();
      test_first_brick();
      test_bounce_x();
      test_large_ball();
      test_midscan_reset();
      test_clear_all();
      test_random();
      test_tick_ignored();
      test_lr_abort();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
